// File: rtl/apb_burst_sequencer.sv
// apb_burst_sequencer
//   Shares one APB master port between the AXI read and write paths.
//   Arbitrates round-robin between rd_req/wr_req, expands the granted AXI
//   burst (FIXED/INCR/WRAP) into one APB transfer per beat, moves data
//   between APB and the read/write FIFOs, and signals completion with an
//   accumulated response.
// Ports
//   clk, rst_n                  clock, async active-low reset
//   rd_*/wr_*                   burst request + descriptor per side
//   rd_grant/wr_grant           level, grant through done cycle inclusive
//   rd_done/wr_done, resp       one-cycle completion pulse + OKAY/SLVERR
//   wf_rdata/wf_empty/wf_pop    write-data FIFO (first-word fall-through)
//   rf_wdata/rf_full/rf_push    read-data FIFO
//   paddr..pslverr              APB master port
module apb_burst_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [3:0]            rd_len,
  input  logic [2:0]            rd_size,
  input  logic [1:0]            rd_burst,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [3:0]            wr_len,
  input  logic [2:0]            wr_size,
  input  logic [1:0]            wr_burst,
  output logic                  rd_grant,
  output logic                  wr_grant,
  output logic                  rd_done,
  output logic                  wr_done,
  output logic [1:0]            resp,
  input  logic [DATA_WIDTH-1:0] wf_rdata,
  input  logic                  wf_empty,
  output logic                  wf_pop,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic                  rf_full,
  output logic                  rf_push,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  typedef enum logic [2:0] {IDLE, LOAD, HOLD, SETUP, ACCESS, DONE} state_t;

  state_t                state_q, state_d;
  logic                  side_q, side_d;   // 1 = write side granted
  logic                  last_wr_q;        // side served most recently
  logic [ADDR_WIDTH-1:0] addr_q, addr_next;
  logic [3:0]            len_q, beat_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  sticky_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  fifo_ok, hold_go, last_beat;
  logic [ADDR_WIDTH-1:0] inc, incr, blen, wmask;

  assign fifo_ok   = side_q ? !wf_empty : !rf_full;
  assign hold_go   = (state_q == HOLD) && fifo_ok;
  assign last_beat = (beat_q == len_q);

  // Next beat address; WRAP keeps the upper bits and wraps the low bits
  // inside the (len+1)<<size aligned window.
  assign inc   = ADDR_WIDTH'(1) << size_q;
  assign incr  = addr_q + inc;
  assign blen  = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
  assign wmask = blen - ADDR_WIDTH'(1);

  always_comb begin
    addr_next = incr;
    case (burst_q)
      2'b00:   addr_next = addr_q;
      2'b10:   addr_next = (addr_q & ~wmask) | (incr & wmask);
      default: addr_next = incr;
    endcase
  end

  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    case (state_q)
      IDLE: if (rd_req || wr_req) begin
        // Contention goes to the side not served last.
        side_d  = (rd_req && wr_req) ? !last_wr_q : wr_req;
        state_d = LOAD;
      end
      LOAD:    state_d = HOLD;
      HOLD:    if (fifo_ok) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready) state_d = last_beat ? DONE : HOLD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      side_q    <= 1'b0;
      last_wr_q <= 1'b1;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      sticky_q  <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      case (state_q)
        LOAD: begin
          addr_q   <= side_q ? wr_addr  : rd_addr;
          len_q    <= side_q ? wr_len   : rd_len;
          size_q   <= side_q ? wr_size  : rd_size;
          burst_q  <= side_q ? wr_burst : rd_burst;
          beat_q   <= '0;
          sticky_q <= 1'b0;
        end
        HOLD: if (hold_go && side_q) pwdata_q <= wf_rdata;
        ACCESS: if (pready) begin
          sticky_q <= sticky_q | pslverr;
          if (!last_beat) begin
            addr_q <= addr_next;
            beat_q <= beat_q + 4'd1;
          end
        end
        DONE: last_wr_q <= side_q;
        default: ;
      endcase
    end
  end

  assign rd_grant = (state_q != IDLE) && !side_q;
  assign wr_grant = (state_q != IDLE) &&  side_q;
  assign rd_done  = (state_q == DONE) && !side_q;
  assign wr_done  = (state_q == DONE) &&  side_q;
  assign resp     = ((state_q == DONE) && sticky_q) ? 2'b10 : 2'b00;
  assign psel     = (state_q == SETUP) || (state_q == ACCESS);
  assign penable  = (state_q == ACCESS);
  assign pwrite   = psel && side_q;
  assign paddr    = addr_q;
  assign pwdata   = pwdata_q;
  assign wf_pop   = hold_go && side_q;
  assign rf_push  = penable && pready && !side_q;
  assign rf_wdata = penable ? prdata : '0;

endmodule

// File: tb/tb_apb_burst_sequencer.sv
// Directed bench for apb_burst_sequencer: FIFO and APB slave models with
// per-beat wait-state / error / read-data tables, transfer recorder.
module tb_apb_burst_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_req = 0, wr_req = 0;
  logic [31:0] rd_addr = 0, wr_addr = 0;
  logic [3:0]  rd_len = 0, wr_len = 0;
  logic [2:0]  rd_size = 0, wr_size = 0;
  logic [1:0]  rd_burst = 0, wr_burst = 0;
  logic        rd_grant, wr_grant, rd_done, wr_done;
  logic [1:0]  resp;
  logic [31:0] wf_rdata, rf_wdata, paddr, pwdata, prdata;
  logic        wf_empty, wf_pop, rf_full = 0, rf_push;
  logic        psel, penable, pwrite, pready, pslverr;

  apb_burst_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_size(rd_size), .rd_burst(rd_burst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_size(wr_size), .wr_burst(wr_burst),
    .rd_grant(rd_grant), .wr_grant(wr_grant), .rd_done(rd_done), .wr_done(wr_done), .resp(resp),
    .wf_rdata(wf_rdata), .wf_empty(wf_empty), .wf_pop(wf_pop),
    .rf_wdata(rf_wdata), .rf_full(rf_full), .rf_push(rf_push),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // write FIFO model
  logic [31:0] wf_mem[16];
  int wf_wr = 0, wf_rd = 0;
  assign wf_empty = (wf_wr == wf_rd);
  assign wf_rdata = wf_mem[wf_rd & 15];

  // APB slave model, tables indexed by transfer number within a burst
  int          ws_tab[8];
  bit          err_tab[8];
  logic [31:0] rd_tab[8];
  int xfer_total = 0, xfer_base = 0, ws_cnt = 0, wait_cyc = 0;
  int xi;
  assign xi      = (xfer_total - xfer_base) & 7;
  assign pready  = penable && (ws_cnt >= ws_tab[xi]);
  assign pslverr = pready && err_tab[xi];
  assign prdata  = rd_tab[xi];

  // recorders
  logic [31:0] rec_addr[64], rec_wd[64], push_d[64];
  bit          rec_wr[64];
  int rec_n = 0, push_n = 0;
  bit bad_pen = 0;

  always @(posedge clk) begin
    if (wf_pop) wf_rd <= wf_rd + 1;
    if (psel && penable) begin
      if (pready) begin
        rec_addr[rec_n & 63] <= paddr;
        rec_wr[rec_n & 63]   <= pwrite;
        rec_wd[rec_n & 63]   <= pwdata;
        rec_n      <= rec_n + 1;
        xfer_total <= xfer_total + 1;
        ws_cnt     <= 0;
      end else begin
        ws_cnt   <= ws_cnt + 1;
        wait_cyc <= wait_cyc + 1;
      end
    end
    if (rf_push) begin
      push_d[push_n & 63] <= rf_wdata;
      push_n <= push_n + 1;
    end
    if (penable && !psel) bad_pen <= 1'b1;
  end

  int rb, pb, wb, wc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_slave();
    for (int i = 0; i < 8; i++) begin
      ws_tab[i] = 0; err_tab[i] = 0; rd_tab[i] = 32'h1000_0000 + i;
    end
  endtask

  task automatic push_wf(input logic [31:0] w);
    wf_mem[wf_wr & 15] = w;
    wf_wr++;
  endtask

  task automatic req(input bit wr, input logic [31:0] a, input logic [3:0] l,
                     input logic [2:0] s, input logic [1:0] b);
    xfer_base = xfer_total; rb = rec_n; pb = push_n; wb = wf_rd; wc = wait_cyc;
    if (wr) begin wr_addr = a; wr_len = l; wr_size = s; wr_burst = b; wr_req = 1; end
    else    begin rd_addr = a; rd_len = l; rd_size = s; rd_burst = b; rd_req = 1; end
  endtask

  // k = edges from request sample to done pulse; g1 = grant one edge later;
  // pf = edge count at first psel
  task automatic wait_done(input bit wr, output int k, output bit g1, output int pf,
                           output logic [1:0] r);
    k = 0; g1 = 0; pf = 0; r = 2'bxx;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1) g1 = wr ? wr_grant : rd_grant;
      if (pf == 0 && psel) pf = i;
      if (wr ? wr_done : rd_done) begin k = i; r = resp; break; end
    end
    n_chk++;
    assert (k != 0) else begin
      n_fail++;
      $error("FAIL done_timeout: observed no done expected done within 100 cycles");
    end
    if (wr) wr_req = 0; else rd_req = 0;
    @(negedge clk);
    chk("done_one_cycle", wr ? wr_done : rd_done, 0);
    chk("grant_drop", wr ? wr_grant : rd_grant, 0);
  endtask

  int k, pf;
  bit g1;
  logic [1:0] r;
  bit found;

  initial begin
    clr_slave();
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_psel", psel, 0);
    chk("rst_outs", {rd_grant, wr_grant, rd_done, wr_done, resp, penable, pwrite,
                     wf_pop, rf_push}, 0);
    chk("rst_paddr", paddr, 0);
    rst_n = 1;
    @(negedge clk);

    // single read INCR 0x100
    rd_tab[0] = 32'hDEADBEEF;
    req(0, 32'h100, 0, 2, 2'b01);
    wait_done(0, k, g1, pf, r);
    chk("rd1_latency", k, 5);
    chk("rd1_grant_t1", g1, 1);
    chk("rd1_first_psel", pf, 3);
    chk("rd1_resp", r, 0);
    chk("rd1_nxfer", rec_n - rb, 1);
    chk("rd1_addr", rec_addr[rb & 63], 32'h100);
    chk("rd1_pwrite", rec_wr[rb & 63], 0);
    chk("rd1_npush", push_n - pb, 1);
    chk("rd1_data", push_d[pb & 63], 32'hDEADBEEF);

    // write INCR 0x200 len 3
    clr_slave();
    for (int i = 0; i < 4; i++) push_wf(32'hA000_0000 + i);
    req(1, 32'h200, 3, 2, 2'b01);
    wait_done(1, k, g1, pf, r);
    chk("wr4_latency", k, 14);
    chk("wr4_grant_t1", g1, 1);
    chk("wr4_resp", r, 0);
    chk("wr4_nxfer", rec_n - rb, 4);
    chk("wr4_pops", wf_rd - wb, 4);
    for (int i = 0; i < 4; i++) begin
      chk("wr4_addr", rec_addr[(rb + i) & 63], 32'h200 + 4 * i);
      chk("wr4_pwrite", rec_wr[(rb + i) & 63], 1);
      chk("wr4_wdata", rec_wd[(rb + i) & 63], 32'hA000_0000 + i);
    end

    // WRAP read 0x34 len 3 -> 34 38 3C 30
    req(0, 32'h34, 3, 2, 2'b10);
    wait_done(0, k, g1, pf, r);
    chk("wrap_latency", k, 14);
    chk("wrap_nxfer", rec_n - rb, 4);
    chk("wrap_a0", rec_addr[rb & 63], 32'h34);
    chk("wrap_a1", rec_addr[(rb + 1) & 63], 32'h38);
    chk("wrap_a2", rec_addr[(rb + 2) & 63], 32'h3C);
    chk("wrap_a3", rec_addr[(rb + 3) & 63], 32'h30);
    chk("wrap_npush", push_n - pb, 4);

    // FIXED read 0x40 len 2
    req(0, 32'h40, 2, 2, 2'b00);
    wait_done(0, k, g1, pf, r);
    chk("fix_latency", k, 11);
    chk("fix_nxfer", rec_n - rb, 3);
    for (int i = 0; i < 3; i++) chk("fix_addr", rec_addr[(rb + i) & 63], 32'h40);

    // arbitration: both high from reset -> R W R W
    @(negedge clk);
    rst_n = 0;
    push_wf(32'hB0); push_wf(32'hB1);
    xfer_base = xfer_total;
    rd_addr = 32'h500; rd_len = 0; rd_size = 2; rd_burst = 2'b01;
    wr_addr = 32'h600; wr_len = 0; wr_size = 2; wr_burst = 2'b01;
    rd_req = 1; wr_req = 1;
    @(negedge clk);
    chk("rst2_grants", {rd_grant, wr_grant, psel}, 0);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      found = 0;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        if (rd_done || wr_done) begin found = 1; break; end
      end
      chk("arb_found", found, 1);
      chk("arb_order_wr", wr_done, (i % 2 == 1));
      chk("arb_order_rd", rd_done, (i % 2 == 0));
    end
    rd_req = 0; wr_req = 0;
    @(negedge clk);
    chk("arb_idle", {rd_grant, wr_grant}, 0);

    // pslverr on beat 1, 2 wait states on beat 2
    clr_slave();
    err_tab[1] = 1; ws_tab[2] = 2;
    for (int i = 0; i < 3; i++) push_wf(32'hC000_0000 + i);
    req(1, 32'h300, 2, 2, 2'b01);
    wait_done(1, k, g1, pf, r);
    chk("err_latency", k, 13);
    chk("err_resp", r, 2'b10);
    chk("err_nxfer", rec_n - rb, 3);
    chk("err_waits", wait_cyc - wc, 2);
    chk("err_a2", rec_addr[(rb + 2) & 63], 32'h308);
    chk("err_wd2", rec_wd[(rb + 2) & 63], 32'hC000_0002);
    clr_slave();

    // rf_full stall mid read burst
    req(0, 32'h80, 2, 2, 2'b01);
    found = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (push_n != pb) begin found = 1; break; end
    end
    chk("stall_first_push", found, 1);
    rf_full = 1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("stall_psel", psel, 0);
      chk("stall_push", rf_push, 0);
    end
    rf_full = 0;
    wait_done(0, k, g1, pf, r);
    chk("stall_resp", r, 0);
    chk("stall_nxfer", rec_n - rb, 3);
    chk("stall_npush", push_n - pb, 3);
    chk("stall_a2", rec_addr[(rb + 2) & 63], 32'h88);

    // reset during ACCESS, then a clean read
    push_wf(32'hD0); push_wf(32'hD1);
    req(1, 32'h700, 1, 2, 2'b01);
    found = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (penable) begin found = 1; break; end
    end
    chk("rstmid_access", found, 1);
    rst_n = 0;
    #1;
    chk("rstmid_apb", {psel, penable, pwrite}, 0);
    chk("rstmid_paddr", paddr, 0);
    chk("rstmid_pwdata", pwdata, 0);
    chk("rstmid_ctl", {rd_grant, wr_grant, rd_done, wr_done, resp, wf_pop, rf_push}, 0);
    wr_req = 0;
    @(negedge clk);
    rst_n = 1;
    wf_wr = wf_rd;
    @(negedge clk);
    clr_slave();
    rd_tab[0] = 32'h1234_5678;
    req(0, 32'h900, 0, 2, 2'b01);
    wait_done(0, k, g1, pf, r);
    chk("post_rst_latency", k, 5);
    chk("post_rst_grant", g1, 1);
    chk("post_rst_addr", rec_addr[rb & 63], 32'h900);
    chk("post_rst_data", push_d[pb & 63], 32'h1234_5678);

    chk("penable_without_psel", bad_pen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/apb_burst_sequencer.md
# apb_burst_sequencer

Sequencer and arbiter that shares the bridge's single APB master port between the AXI read path and the AXI write path. Once a slave-side front end has captured an AR or AW request, it raises a request with the burst descriptor. This block grants one side round-robin, expands the AXI burst into one APB transfer per beat, and moves data between APB and the read-data / write-data FIFOs. It reports completion with an accumulated response.

## Interface
- ADDR_WIDTH, 32, APB/AXI address width
- DATA_WIDTH, 32, data width; bursts use size ≤ log2(DATA_WIDTH/8)
- clk  in  1  clock; reset rst_n, asynchronous, active-low; clock clk
- rst_n  in  1  asynchronous active-low reset
- rd_req, wr_req  in  1  burst request from read/write front end; held high until matching done
- rd_addr, wr_addr  in  ADDR_WIDTH  burst start address
- rd_len, wr_len  in  4  beats−1
- rd_size, wr_size  in  3  log2 bytes per beat
- rd_burst, wr_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 treated as INCR
- rd_grant, wr_grant  out  1  level, high from grant to done inclusive
- rd_done, wr_done  out  1  one-cycle pulse after last beat
- resp  out  2  00 OKAY / 10 SLVERR, valid with done pulse
- wf_rdata  in  DATA_WIDTH  write FIFO head (first-word fall-through)
- wf_empty  in  1  write FIFO empty
- wf_pop  out  1  write FIFO pop
- rf_wdata  out  DATA_WIDTH  read FIFO push data (= prdata)
- rf_full  in  1  read FIFO full
- rf_push  out  1  read FIFO push
- paddr  out  ADDR_WIDTH; psel, penable, pwrite  out  1; pwdata  out  DATA_WIDTH
- prdata  in  DATA_WIDTH; pready, pslverr  in  1

## Operation
- States: IDLE, LOAD, HOLD, SETUP, ACCESS, DONE.
- IDLE: sample requests. If only one is high, grant it. If both are high, grant the side not served last; the pointer resets to "write last", so read wins first. Go to LOAD.
- LOAD: latch addr/len/size/burst of the granted side and clear beat counter and sticky error. Go to HOLD.
- HOLD: wait until the data path is ready, then enter SETUP.
  - Write: ready when !wf_empty. wf_pop=1 for that cycle and pwdata ← wf_rdata.
  - Read: ready when !rf_full.
- SETUP: psel=1, penable=0, pwrite=grant side, paddr=current address. Go to ACCESS.
- ACCESS: psel=1, penable=1 until pready.
  - On pready for a read: rf_push=1 and rf_wdata=prdata in the same cycle.
  - On pready, pslverr ORs into the sticky error.
  - If beat == len, go to DONE. Otherwise advance the address, increment beat, and go to HOLD.
- DONE: pulse the done signal for the granted side, resp = sticky ? 10 : 00, drop psel, update the arbitration pointer, and return to IDLE. The grant deasserts on the cycle after DONE.
- Address update, with inc = 1<<size:
  - FIXED: unchanged.
  - INCR: addr+inc, modulo 2^ADDR_WIDTH.
  - WRAP: B=(len+1)<<size, addr = (addr & ~(B−1)) | ((addr+inc) & (B−1)).
- pslverr never aborts a burst; all len+1 beats are issued.

## Timing
- Reset values: all outputs 0. Reset also sets state IDLE, pointer "write last", beat 0, sticky 0.
- Reset mid-burst drops psel/penable immediately (asynchronous). No done pulse is issued.
- Request sampled in IDLE at cycle t: grant high at t+1, first psel at t+3 (LOAD, HOLD, SETUP), assuming the FIFO is ready.
- Per beat, with pready=1 and FIFO ready: 3 cycles (HOLD, SETUP, ACCESS).
- A burst of N beats with zero wait states: done pulse at t+1+3N+1.
- paddr, pwrite and pwdata are stable from SETUP through the last ACCESS cycle of the beat. penable is never high without psel.
- FIFO stall (wf_empty or rf_full) holds the FSM in HOLD with psel=0. No APB transfer is ever started without FIFO space or data.
- A request arriving while busy waits. A request that drops before grant is ignored.

## Test plan
- Single read, INCR, addr 0x100, len 0, size 2, prdata 0xDEADBEEF → one APB read at 0x100, rf_push once with 0xDEADBEEF, rd_done, resp 00.
- Write INCR, addr 0x200, len 3, size 2, FIFO holds 4 words → paddr 0x200/0x204/0x208/0x20C, 4 pops, wr_done after 14 cycles from request sample.
- WRAP read, addr 0x34, len 3, size 2 → paddr 0x34, 0x38, 0x3C, 0x30. FIXED at 0x40, len 2 → 0x40 three times.
- rd_req and wr_req both high from reset → read served first, then write. Repeating both → strict alternation.
- pslverr on beat 1 of a 3-beat write, plus pready low 2 cycles on beat 2 → all 3 beats issued, wait states honoured, resp 10.
- rf_full high for 5 cycles mid read burst → psel stays 0 during stall, no rf_push while full. Assert rst_n low in ACCESS → all outputs 0, next request granted cleanly.
